// File: rtl/lock_pkg.sv
// Shared definitions for the lock/sweep controller: state encoding, widths and
// the {on, hold, locked} control pattern driven in each state.
package lock_pkg;
    localparam int STATE_W             = 3;
    localparam int DEFAULT_SIGNAL_SIZE = 25;
    localparam int DEFAULT_CW          = 24;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SWEEP   = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_HOLD    = 3'd4
    } lock_state_t;

    // Returns {on, hold, locked} for a state.
    function automatic logic [2:0] ctrl_of(input lock_state_t s);
        case (s)
            ST_ACQUIRE: return 3'b100;
            ST_LOCKED:  return 3'b101;
            ST_HOLD:    return 3'b110;
            default:    return 3'b000;
        endcase
    endfunction
endpackage

// File: rtl/tri_sweep.sv
// Triangle sweep generator bouncing between SLL and SUL. The first run cycle
// after a clear loads SLL; later run cycles advance by step.
module tri_sweep
    import lock_pkg::*;
#(
    parameter int SIGNAL_SIZE = DEFAULT_SIGNAL_SIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          clear,
    input  logic signed [SIGNAL_SIZE-1:0] SLL,
    input  logic signed [SIGNAL_SIZE-1:0] SUL,
    input  logic signed [SIGNAL_SIZE-1:0] step,
    output logic signed [SIGNAL_SIZE-1:0] out
);
    logic signed [SIGNAL_SIZE-1:0] out_reg;
    logic                          dir_down_reg;
    logic                          primed_reg;
    logic signed [SIGNAL_SIZE:0]   cur_w;
    logic signed [SIGNAL_SIZE:0]   step_w;
    logic signed [SIGNAL_SIZE:0]   sll_w;
    logic signed [SIGNAL_SIZE:0]   sul_w;
    logic signed [SIGNAL_SIZE:0]   nxt_w;

    // One extra bit of headroom so stepping past a rail cannot wrap.
    always_comb begin
        cur_w  = {out_reg[SIGNAL_SIZE-1], out_reg};
        step_w = {step[SIGNAL_SIZE-1], step};
        sll_w  = {SLL[SIGNAL_SIZE-1], SLL};
        sul_w  = {SUL[SIGNAL_SIZE-1], SUL};
        nxt_w  = dir_down_reg ? (cur_w - step_w) : (cur_w + step_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg      <= '0;
            dir_down_reg <= 1'b0;
            primed_reg   <= 1'b0;
        end else if (clear) begin
            out_reg      <= '0;
            dir_down_reg <= 1'b0;
            primed_reg   <= 1'b0;
        end else if (run) begin
            if (!primed_reg) begin
                out_reg      <= SLL;
                dir_down_reg <= 1'b0;
                primed_reg   <= 1'b1;
            end else if (SLL >= SUL) begin
                out_reg <= SLL;
            end else if (nxt_w >= sul_w) begin
                out_reg      <= SUL;
                dir_down_reg <= 1'b1;
            end else if (nxt_w <= sll_w) begin
                out_reg      <= SLL;
                dir_down_reg <= 1'b0;
            end else begin
                out_reg <= nxt_w[SIGNAL_SIZE-1:0];
            end
        end
    end

    assign out = out_reg;
endmodule

// File: rtl/lock_sweep_ctrl.sv
// Lock acquisition controller: sweeps the actuator until the lock indicator is
// seen, lets the servo settle, then supervises the lock and recovers from loss.
module lock_sweep_ctrl
    import lock_pkg::*;
#(
    parameter int SIGNAL_SIZE = DEFAULT_SIGNAL_SIZE,
    parameter int CW          = DEFAULT_CW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic signed [SIGNAL_SIZE-1:0] level_in,
    input  logic signed [SIGNAL_SIZE-1:0] TH,
    input  logic signed [SIGNAL_SIZE-1:0] s_fb,
    input  logic signed [SIGNAL_SIZE-1:0] LL,
    input  logic signed [SIGNAL_SIZE-1:0] UL,
    input  logic signed [SIGNAL_SIZE-1:0] SLL,
    input  logic signed [SIGNAL_SIZE-1:0] SUL,
    input  logic signed [SIGNAL_SIZE-1:0] step,
    input  logic        [CW-1:0]          n_conf,
    input  logic        [CW-1:0]          n_settle,
    input  logic        [CW-1:0]          n_loss,
    input  logic        [CW-1:0]          n_hold,
    output logic                          on,
    output logic                          hold,
    output logic signed [SIGNAL_SIZE-1:0] sweep_out,
    output logic                          locked,
    output logic        [STATE_W-1:0]     state
);
    lock_state_t   state_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_inc;
    logic [2:0]    ctrl_reg;
    logic          present;
    logic          railed;
    logic          conf_hit;
    logic          settle_hit;
    logic          loss_hit;
    logic          hold_hit;
    logic          sweep_run;
    logic          sweep_clear;

    function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] n);
        return (n == '0) ? {{(CW-1){1'b0}}, 1'b1} : n;
    endfunction

    always_comb begin
        present     = (level_in >= TH);
        railed      = (s_fb <= LL) || (s_fb >= UL);
        cnt_inc     = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
        conf_hit    = present && (cnt_inc >= at_least_one(n_conf));
        settle_hit  = present && (cnt_inc >= at_least_one(n_settle));
        loss_hit    = !present && (cnt_inc >= at_least_one(n_loss));
        hold_hit    = (cnt_inc >= at_least_one(n_hold));
        sweep_clear = !enable;
        // The sweep freezes on the edge that leaves SWEEP so ACQUIRE sees the hit position.
        sweep_run   = enable && ((state_reg == ST_IDLE) ||
                                 ((state_reg == ST_SWEEP) && !conf_hit));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ctrl_reg  <= 3'b000;
        end else if (!enable) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ctrl_reg  <= 3'b000;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_SWEEP;
                    cnt_reg   <= '0;
                    ctrl_reg  <= ctrl_of(ST_SWEEP);
                end
                ST_SWEEP: begin
                    if (conf_hit) begin
                        state_reg <= ST_ACQUIRE;
                        cnt_reg   <= '0;
                        ctrl_reg  <= ctrl_of(ST_ACQUIRE);
                    end else begin
                        cnt_reg <= present ? cnt_inc : '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (!present) begin
                        state_reg <= ST_SWEEP;
                        cnt_reg   <= '0;
                        ctrl_reg  <= ctrl_of(ST_SWEEP);
                    end else if (settle_hit) begin
                        state_reg <= ST_LOCKED;
                        cnt_reg   <= '0;
                        ctrl_reg  <= ctrl_of(ST_LOCKED);
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                ST_LOCKED: begin
                    if (railed || loss_hit) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= '0;
                        ctrl_reg  <= ctrl_of(ST_HOLD);
                    end else begin
                        cnt_reg <= present ? '0 : cnt_inc;
                    end
                end
                ST_HOLD: begin
                    // Timeout outranks recovery when both fire together.
                    if (hold_hit) begin
                        state_reg <= ST_SWEEP;
                        cnt_reg   <= '0;
                        ctrl_reg  <= ctrl_of(ST_SWEEP);
                    end else if (present && !railed) begin
                        state_reg <= ST_LOCKED;
                        cnt_reg   <= '0;
                        ctrl_reg  <= ctrl_of(ST_LOCKED);
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    ctrl_reg  <= 3'b000;
                end
            endcase
        end
    end

    tri_sweep #(
        .SIGNAL_SIZE(SIGNAL_SIZE)
    ) u_tri_sweep (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (sweep_run),
        .clear (sweep_clear),
        .SLL   (SLL),
        .SUL   (SUL),
        .step  (step),
        .out   (sweep_out)
    );

    assign {on, hold, locked} = ctrl_reg;
    assign state              = state_reg;
endmodule

// File: tb/tb_lock_sweep_ctrl.sv
// Bench for lock_sweep_ctrl: directed vector table, corner-case sequences and
// randomized traffic checked against a behavioural model.
module tb_lock_sweep_ctrl;
    localparam int S = 25;
    localparam int C = 24;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                enable;
    logic signed [S-1:0] level_in, TH, s_fb, LL, UL, SLL, SUL, step;
    logic        [C-1:0] n_conf, n_settle, n_loss, n_hold;
    logic                on, hold, locked;
    logic signed [S-1:0] sweep_out;
    logic        [2:0]   state;

    int tests = 0;
    int fails = 0;
    int m_state, m_cnt, m_out, m_dir;

    typedef struct {
        logic en;
        int   lvl;
        int   sfb;
        int   st;
        int   sw;
    } vec_t;
    vec_t tbl[$];

    lock_sweep_ctrl #(.SIGNAL_SIZE(S), .CW(C)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .level_in(level_in), .TH(TH),
        .s_fb(s_fb), .LL(LL), .UL(UL), .SLL(SLL), .SUL(SUL), .step(step),
        .n_conf(n_conf), .n_settle(n_settle), .n_loss(n_loss), .n_hold(n_hold),
        .on(on), .hold(hold), .sweep_out(sweep_out), .locked(locked), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic int eff(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_out = 0; m_dir = 0;
    endtask

    task automatic model_advance();
        int n;
        if (int'(SLL) >= int'(SUL)) begin
            m_out = int'(SLL);
        end else begin
            n = (m_dir != 0) ? m_out - int'(step) : m_out + int'(step);
            if (n >= int'(SUL)) begin
                m_out = int'(SUL); m_dir = 1;
            end else if (n <= int'(SLL)) begin
                m_out = int'(SLL); m_dir = 0;
            end else begin
                m_out = n;
            end
        end
    endtask

    task automatic model_step();
        bit pres, rail;
        pres = (int'(level_in) >= int'(TH));
        rail = (int'(s_fb) <= int'(LL)) || (int'(s_fb) >= int'(UL));
        if (!enable) begin
            model_reset();
        end else begin
            case (m_state)
                0: begin m_state = 1; m_out = int'(SLL); m_dir = 0; m_cnt = 0; end
                1: begin
                    if (pres) begin
                        m_cnt++;
                        if (m_cnt >= eff(int'(n_conf))) begin m_state = 2; m_cnt = 0; end
                        else model_advance();
                    end else begin
                        m_cnt = 0; model_advance();
                    end
                end
                2: begin
                    if (!pres) begin m_state = 1; m_cnt = 0; end
                    else begin
                        m_cnt++;
                        if (m_cnt >= eff(int'(n_settle))) begin m_state = 3; m_cnt = 0; end
                    end
                end
                3: begin
                    if (rail) begin m_state = 4; m_cnt = 0; end
                    else if (!pres) begin
                        m_cnt++;
                        if (m_cnt >= eff(int'(n_loss))) begin m_state = 4; m_cnt = 0; end
                    end else m_cnt = 0;
                end
                default: begin
                    m_cnt++;
                    if (m_cnt >= eff(int'(n_hold))) begin m_state = 1; m_cnt = 0; end
                    else if (pres && !rail) begin m_state = 3; m_cnt = 0; end
                end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input int st, input int o, input int h,
                         input int lk, input int sw);
        tests++;
        if (int'(state) != st || int'(on) != o || int'(hold) != h ||
            int'(locked) != lk || int'(sweep_out) != sw) begin
            fails++;
            $display("FAIL %s: got st=%0d on=%0d hold=%0d lk=%0d sw=%0d, expected st=%0d on=%0d hold=%0d lk=%0d sw=%0d",
                     name, state, on, hold, locked, sweep_out, st, o, h, lk, sw);
        end else begin
            $display("[TB] %s st=%0d on=%0d hold=%0d lk=%0d sw=%0d",
                     name, state, on, hold, locked, sweep_out);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_state, (m_state >= 2) ? 1 : 0, (m_state == 4) ? 1 : 0,
              (m_state == 3) ? 1 : 0, m_out);
    endtask

    task automatic run_until(input int target, input int maxc);
        for (int i = 0; i < maxc && m_state != target; i++) begin
            cycle();
            check_model("seek");
        end
    endtask

    task automatic add(input logic en, input int lvl, input int sfb, input int st, input int sw);
        vec_t v;
        v.en = en; v.lvl = lvl; v.sfb = sfb; v.st = st; v.sw = sw;
        tbl.push_back(v);
    endtask

    initial begin
        int sweep_seq[10] = '{-100, -70, -40, -10, 20, 50, 80, 100, 70, 40};
        vec_t v;
        int bias, r;

        // Sweep, acquire, rail, loss, timeout and glitch vectors (absent=0, present=60).
        foreach (sweep_seq[i]) add(1'b1, 0, 0, 1, sweep_seq[i]);
        add(1'b1, 60, 0, 1, 10);
        add(1'b1, 60, 0, 1, -20);
        for (int i = 0; i < 5; i++) add(1'b1, 60, 0, 2, -20);
        add(1'b1, 60, 0, 3, -20);
        add(1'b1, 60, 1000, 4, -20);
        add(1'b1, 60, 0, 3, -20);
        add(1'b1, 0, 0, 3, -20);
        add(1'b1, 0, 0, 4, -20);
        for (int i = 0; i < 3; i++) add(1'b1, 0, 0, 4, -20);
        add(1'b1, 0, 0, 1, -20);
        add(1'b1, 0, 0, 1, -50);
        add(1'b1, 60, 0, 1, -80);
        add(1'b1, 60, 0, 1, -100);
        add(1'b1, 60, 0, 2, -100);
        add(1'b1, 0, 0, 1, -100);
        add(1'b1, 0, 0, 1, -70);

        enable = 1'b0; level_in = '0; TH = S'(50); s_fb = '0;
        LL = S'(-1000); UL = S'(1000); SLL = S'(-100); SUL = S'(100); step = S'(30);
        n_conf = C'(3); n_settle = C'(5); n_loss = C'(2); n_hold = C'(4);

        #2 rst_n = 1'b0;
        #1 check("reset", 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        cycle();
        check("idle_en0", 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            enable = v.en; level_in = S'(v.lvl); s_fb = S'(v.sfb);
            cycle();
            check($sformatf("vec%0d", i), v.st, (v.st >= 2) ? 1 : 0, (v.st == 4) ? 1 : 0,
                  (v.st == 3) ? 1 : 0, v.sw);
        end

        // Asynchronous reset while locked.
        level_in = S'(60); s_fb = '0;
        run_until(3, 30);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Rail into HOLD, then drop enable.
        run_until(3, 30);
        s_fb = S'(1000);
        cycle();
        check("rail_hold", 4, 1, 1, 0, m_out);
        s_fb = '0; enable = 1'b0;
        cycle();
        check("en_off_hold", 0, 0, 0, 0, 0);

        // Degenerate sweep limits.
        SLL = S'(50); SUL = S'(50); enable = 1'b1; level_in = '0;
        for (int i = 0; i < 4; i++) begin cycle(); check("sll_eq_sul", 1, 0, 0, 0, 50); end
        enable = 1'b0;
        cycle(); check_model("cfg");
        SLL = S'(80); SUL = S'(20); enable = 1'b1;
        for (int i = 0; i < 3; i++) begin cycle(); check("sll_gt_sul", 1, 0, 0, 0, 80); end

        // Zero counts qualify after one cycle.
        enable = 1'b0; SLL = S'(-100); SUL = S'(100); n_conf = '0; n_settle = '0;
        cycle(); check_model("cfg");
        enable = 1'b1;
        cycle(); check("nconf0_sweep", 1, 0, 0, 0, -100);
        level_in = S'(60);
        cycle(); check("nconf0_acq", 2, 1, 0, 0, -100);
        cycle(); check("nsettle0_lock", 3, 1, 0, 1, -100);

        // Randomized traffic against the model.
        for (int blk = 0; blk < 30; blk++) begin
            enable = 1'b0;
            SLL = S'(int'($urandom_range(0, 1000)) - 500);
            SUL = S'(int'($urandom_range(0, 1000)) - 500);
            step = S'($urandom_range(1, 200));
            TH = S'(int'($urandom_range(0, 400)) - 200);
            n_conf = C'($urandom_range(0, 5)); n_settle = C'($urandom_range(0, 5));
            n_loss = C'($urandom_range(0, 5)); n_hold = C'($urandom_range(0, 5));
            bias = int'($urandom_range(50, 95));
            cycle(); check_model("rnd_cfg");
            for (int c = 0; c < 50; c++) begin
                enable = ($urandom_range(0, 99) != 0);
                if (int'($urandom_range(0, 99)) < bias)
                    level_in = S'(int'(TH) + int'($urandom_range(0, 50)));
                else
                    level_in = S'(int'(TH) - 1 - int'($urandom_range(0, 50)));
                r = int'($urandom_range(0, 29));
                s_fb = (r == 0) ? UL : (r == 1) ? LL : (r == 2) ? S'(int'(UL) - 1) : '0;
                cycle();
                check_model("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lock_sweep_ctrl.md
LOCK_SWEEP_CTRL -- requirements
Module: lock_sweep_ctrl

Interface
REQ-001 Parameter SIGNAL_SIZE, default 25, width of the signed signal, level and limit ports.
REQ-002 Parameter CW, default 24, width of all cycle-count inputs and internal counters.
REQ-003 clk  input  1  single system clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  master enable; 0 forces IDLE.
REQ-006 level_in  input  SIGNAL_SIZE signed  lock-indicator level (e.g. transmission).
REQ-007 TH  input  SIGNAL_SIZE signed  lock threshold; "present" means level_in >= TH.
REQ-008 s_fb  input  SIGNAL_SIZE signed  servo filter output, monitored for rails.
REQ-009 LL, UL  input  SIGNAL_SIZE signed  servo rails; "railed" means s_fb <= LL or s_fb >= UL.
REQ-010 SLL, SUL, step  input  SIGNAL_SIZE signed  sweep lower limit, upper limit and positive step size.
REQ-011 n_conf, n_settle, n_loss, n_hold  input  CW unsigned  confirm, settle, loss and hold-timeout cycle counts.
REQ-012 on, hold  output  1  servo enable/hold controls, {on,hold} encoded as the servo expects: 10 run, 11 hold, 0x off.
REQ-013 sweep_out  output  SIGNAL_SIZE signed  sweep offset added to the actuator.
REQ-014 locked  output  1  high only in LOCKED.
REQ-015 state  output  3  current state code.

Function
REQ-016 The FSM SHALL have states IDLE=0, SWEEP=1, ACQUIRE=2, LOCKED=3, HOLD=4; all outputs are registered.
REQ-017 Any state with enable=0 SHALL go to IDLE next cycle: on=0, hold=0, locked=0, sweep_out=0, counters cleared, direction=up.
REQ-018 IDLE with enable=1 SHALL enter SWEEP next cycle with sweep_out=SLL.
REQ-019 SWEEP: on=0; each cycle sweep_out moves by step in the current direction, computed at SIGNAL_SIZE+1 bits; if result >= SUL it loads SUL and the direction becomes down; if <= SLL it loads SLL and the direction becomes up.
REQ-020 SWEEP: a counter SHALL count consecutive present cycles and reset to 0 on any absent cycle; when it reaches n_conf, the FSM enters ACQUIRE with sweep_out frozen.
REQ-021 ACQUIRE: on=1, hold=0; count n_settle cycles; any absent cycle returns to SWEEP (on=0 next cycle, sweep resumes from frozen value, same direction); count reached enters LOCKED.
REQ-022 LOCKED: on=1, hold=0, locked=1, sweep_out frozen; n_loss consecutive absent cycles or one railed cycle enters HOLD.
REQ-023 HOLD: on=1, hold=1, locked=0; a present cycle with s_fb not railed returns to LOCKED; n_hold cycles elapsed enters SWEEP.
REQ-024 Priority when several transitions fire in one cycle: enable=0, then railed, then loss/timeout, then confirm/recover.
REQ-025 A count value of 0 SHALL behave as 1, so every transition takes at least one cycle of qualification.
REQ-026 If SLL >= SUL, sweep_out SHALL hold at SLL and never advance.
REQ-027 Counters SHALL saturate at all-ones and never wrap.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, on=0, hold=0, locked=0, sweep_out=0, direction=up, all counters 0.
REQ-029 Reset released mid-sweep SHALL restart from IDLE; no state is retained.

Structure
REQ-030 A shared package lock_pkg SHALL hold the state enumeration, the 3-bit state width and the default SIGNAL_SIZE/CW constants.
REQ-031 The triangle generator SHALL be one sub-module, tri_sweep (ports: clk, rst_n, run, clear, SLL, SUL, step, out); the FSM and counters stay in lock_sweep_ctrl.

Verification
REQ-032 Sweep: SLL=-100, SUL=100, step=30, level always absent -> sweep_out -100,-70,-40,-10,20,50,80,100,70,... with on=0 throughout.
REQ-033 Acquire: n_conf=3, n_settle=5, level present from cycle k -> ACQUIRE at k+3 (on=1), LOCKED and locked=1 at k+8, sweep_out frozen.
REQ-034 Glitch: in ACQUIRE, one absent cycle -> SWEEP next cycle, on=0, sweep continues from frozen value in the same direction.
REQ-035 Rail: LOCKED with UL=1000 and s_fb=1000 -> HOLD next cycle ({on,hold}=11); level present and s_fb=0 -> LOCKED.
REQ-036 Timeout: HOLD with n_hold=4 and level absent -> SWEEP after 4 cycles, on=0.
REQ-037 Reset/enable: rst_n pulsed low in LOCKED -> all outputs 0 immediately (asynchronous); enable=0 in HOLD -> IDLE and sweep_out=0 next cycle.
